// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target (slave) and the team's I2C master:
// target FSM state encoding, byte/bit-count constants and the R/W and ACK
// bit values used on the wire.
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_DATA,
        ST_RX_ACK,
        ST_TX_DATA,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam int         I2C_BITS_PER_BYTE = 8;
    localparam logic       I2C_ACK           = 1'b0;
    localparam logic       I2C_NACK          = 1'b1;
    localparam logic       RW_WRITE          = 1'b0;
    localparam logic       RW_READ           = 1'b1;

    // Bit counter counts down from the MSB index to 0.
    localparam logic [2:0] BIT_CNT_MSB       = 3'(I2C_BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_sync_edge.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge
// Brings one asynchronous bus line into the clk domain through a
// SYNC_STAGES-deep synchronizer followed by a history flop, and reports the
// synced level plus single-clk rise/fall strobes.
//
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   line      raw bus line (SCL or SDA)
//   level     synchronized line value
//   rise      one-clk strobe on a synced 0->1 transition
//   fall      one-clk strobe on a synced 1->0 transition
// ---------------------------------------------------------------------------
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   hist;

    // Reset to the idle-bus level (pulled high) so leaving reset never
    // fabricates an edge on an idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= '1;
            hist      <= 1'b1;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], line};
            hist      <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign level = sync_pipe[SYNC_STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/i2c_slave_controller.sv
// ---------------------------------------------------------------------------
// i2c_slave_controller
// 7-bit-address I2C target. Oversamples SCL/SDA on clk, detects START/STOP,
// matches SLAVE_ADDR, ACKs, and shifts bytes in (master write) or out
// (master read). No clock stretching, no general call.
//
// Ports:
//   clk       system clock (>= 16x SCL)
//   rst       asynchronous reset, active-high
//   i2c_scl   bus clock, input only
//   i2c_sda   open-drain data; pulled to 0 when the target drives, else 'z'
//   rx_data   last byte written by the master
//   rx_valid  one-clk pulse when rx_data updates
//   tx_data   byte returned on a master read, captured on tx_load
//   tx_load   one-clk pulse when tx_data is captured
//   busy      high from address match until STOP, repeated START or mismatch
// ---------------------------------------------------------------------------
module i2c_slave_controller
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (i2c_scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (i2c_sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Both lines share the same synchronizer depth, so their relative
    // ordering is preserved and SCL's synced level is valid here.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;     // previously received bits of the byte
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       rw_q, rw_d;
    // phase: in *_ACK states, ACK already driven / master ACK seen;
    // in TX_DATA, bit0 has been clocked and the next fall ends the byte.
    logic       phase_q, phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;

    logic [7:0] byte_in;
    assign byte_in = {shreg_q, sda_lvl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= BIT_CNT_MSB;
            shreg_q    <= '0;
            tx_sh_q    <= '0;
            rw_q       <= RW_WRITE;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_sh_q    <= tx_sh_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_sh_d    = tx_sh_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        if (start_det) begin
            // Covers both a first START and a repeated START.
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = BIT_CNT_MSB;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd0) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = byte_in[0];
                                phase_d = 1'b0;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = BIT_CNT_MSB;
                            if (rw_q == RW_READ) begin
                                // Release the ACK and present bit7 in one clk.
                                tx_sh_d   = tx_data;
                                tx_load_d = 1'b1;
                                sda_oe_d  = ~tx_data[7];
                                state_d   = ST_TX_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_RX_DATA;
                            end
                        end
                    end
                end

                ST_RX_DATA: begin
                    if (scl_rise) begin
                        shreg_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd0) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = ST_RX_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = BIT_CNT_MSB;
                            state_d   = ST_RX_DATA;
                        end
                    end
                end

                ST_TX_DATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd0) phase_d = 1'b1;
                        else                   bit_cnt_d = bit_cnt_q - 3'd1;
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            sda_oe_d = ~tx_sh_q[bit_cnt_q];
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) state_d = ST_WAIT_STOP;
                        else                     phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        tx_sh_d   = tx_data;
                        tx_load_d = 1'b1;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = BIT_CNT_MSB;
                        phase_d   = 1'b0;
                        state_d   = ST_TX_DATA;
                    end
                end

                ST_WAIT_STOP: sda_oe_d = 1'b0;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Open drain: only ever pull low.
    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_controller
// Bit-banged I2C master driving the target through write, mismatch, read,
// repeated-start and abort/reset sequences. Expected write bytes and read
// bytes are queued when the stimulus is issued and popped when the target
// produces them.
// ---------------------------------------------------------------------------
module tb_i2c_slave_controller;
    import i2c_pkg::*;

    localparam time Q = 80ns;   // quarter SCL period; SCL = clk/32

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       master_oe;      // 1 = master pulls SDA low
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       busy;
    wire        sda_bus;

    assign sda_bus = master_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_controller #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (scl),
        .i2c_sda  (sda_bus),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    always #5ns clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] tx_next_q[$];
    int rx_cnt = 0, rx_total = 0;
    int tx_load_cnt = 0;
    int slave_low_cnt = 0;
    logic busy_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors sample on the falling clk edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            check("rx_expected", 32'(rx_exp_q.size() != 0), 32'd1);
            if (rx_exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        end
        if (tx_load) begin
            tx_load_cnt++;
            if (tx_next_q.size() != 0) tx_data = tx_next_q.pop_front();
        end
        if (!master_oe && sda_bus === 1'b0) slave_low_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- bus primitives (SCL low on entry/exit except START) --
    task automatic i2c_start();
        master_oe = 1'b0; #Q;
        scl = 1'b1;       #Q;
        master_oe = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic i2c_stop();
        master_oe = 1'b1; #Q;
        scl = 1'b1;       #Q;
        master_oe = 1'b0; #Q;
    endtask

    task automatic write_bit(input logic b);
        master_oe = ~b; #Q;
        scl = 1'b1;     #(2*Q);
        scl = 1'b0;     #Q;
    endtask

    task automatic read_bit(output logic b);
        master_oe = 1'b0; #Q;
        scl = 1'b1;       #Q;
        b = sda_bus;      #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] b);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            b[i] = bv;
        end
        write_bit(ack_in);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         low0, rx0;

        rst = 1'b1; scl = 1'b1; master_oe = 1'b0; tx_data = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",  32'(rx_data),  32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_tx_load",  32'(tx_load),  32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_sda",      32'(sda_bus),  32'd1);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // ---- write 0xA5 to 0x50 ----
        i2c_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("wr_busy", 32'(busy), 32'd1);
        rx_exp_q.push_back(8'hA5); rx_total++;
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        check("wr_busy_after_stop", 32'(busy), 32'd0);
        check("wr_rx_count", 32'(rx_cnt), 32'(rx_total));

        // ---- address mismatch ----
        low0 = slave_low_cnt; rx0 = rx_cnt; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack);
        check("mm_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'hFF, ack);
        check("mm_data_nack", 32'(ack), 32'(I2C_NACK));
        i2c_stop();
        check("mm_sda_never_low", 32'(slave_low_cnt - low0), 32'd0);
        check("mm_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("mm_busy_never", 32'(busy_seen), 32'd0);

        // ---- read two bytes, ACK then NACK ----
        tx_load_cnt = 0;
        tx_data = 8'h3C;
        tx_next_q.push_back(8'hC3);
        rd_exp_q.push_back(8'h3C);
        rd_exp_q.push_back(8'hC3);
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_byte(I2C_ACK, rd);
        check("rd_byte1", 32'(rd), 32'(rd_exp_q.pop_front()));
        read_byte(I2C_NACK, rd);
        check("rd_byte2", 32'(rd), 32'(rd_exp_q.pop_front()));
        low0 = slave_low_cnt;
        #(2*Q);
        check("rd_released_after_nack", 32'(slave_low_cnt - low0), 32'd0);
        check("rd_tx_load_count", 32'(tx_load_cnt), 32'd2);
        i2c_stop();
        check("rd_busy_after_stop", 32'(busy), 32'd0);

        // ---- write 0x12, repeated START, read 0x5A ----
        tx_data = 8'h5A;
        rd_exp_q.push_back(8'h5A);
        i2c_start();
        write_byte(8'hA0, ack);
        check("sr_wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        rx_exp_q.push_back(8'h12); rx_total++;
        write_byte(8'h12, ack);
        check("sr_wr_data_ack", 32'(ack), 32'(I2C_ACK));
        check("sr_busy_before", 32'(busy), 32'd1);
        i2c_start();
        check("sr_busy_dropped", 32'(busy), 32'd0);
        write_byte(8'hA1, ack);
        check("sr_rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("sr_busy_rematch", 32'(busy), 32'd1);
        read_byte(I2C_NACK, rd);
        check("sr_rd_byte", 32'(rd), 32'(rd_exp_q.pop_front()));
        i2c_stop();
        check("sr_rx_data", 32'(rx_data), 32'h12);
        check("sr_busy_after_stop", 32'(busy), 32'd0);

        // ---- STOP after 4 data bits ----
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        check("ab_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("ab_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("ab_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("ab_busy", 32'(busy), 32'd0);

        // ---- reset while the target drives a 0 data bit ----
        tx_data = 8'h0F;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rs_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("rs_sda_driven_low", 32'(sda_bus), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1ns;
        check("rs_sda_released", 32'(sda_bus), 32'd1);
        check("rs_busy",     32'(busy),     32'd0);
        check("rs_rx_data",  32'(rx_data),  32'h00);
        check("rs_rx_valid", 32'(rx_valid), 32'd0);
        check("rs_tx_load",  32'(tx_load),  32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        i2c_stop();

        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        check("rx_total", 32'(rx_cnt), 32'(rx_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
